ex_iter_divider: RTL and testbench

//   Parametrised iterative integer divider for the EX stage; successor to the fixed 32-bit divider.
//   EX drives one request with a valid/ready handshake and stalls (EX_ready_go low) until out_valid.

---
 rtl/ex_iter_divider.sv | 172 +++++++++++++++++
 tb/tb_ex_iter_divider.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_iter_divider.sv
// ex_iter_divider: iterative restoring integer divider for the EX stage.
// Radix 2^BITS_PER_CYCLE, signed/unsigned, quotient or remainder, flush-cancel.
//
// Ports:
//   clk        in   1     clock, rising edge
//   resetn     in   1     asynchronous active-low reset
//   in_valid   in   1     request valid
//   in_ready   out  1     request accepted when high (IDLE only)
//   op_signed  in   1     1: signed operands
//   op_rem     in   1     1: return remainder, 0: quotient
//   src1       in   XLEN  dividend
//   src2       in   XLEN  divisor
//   flush      in   1     cancel any operation in progress
//   out_valid  out  1     result valid, held until out_ready
//   out_ready  in   1     consumer accepts result
//   result     out  XLEN  quotient or remainder
//   busy       out  1     unit not idle
module ex_iter_divider #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_signed,
    input  logic            op_rem,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    // Holds the dividend; quotient bits shift in at the LSB end.
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_sel_rem;
    logic            r_divzero;
    logic            r_out_valid;
    logic            r_in_ready;
    logic            r_busy;
    logic [XLEN-1:0] r_result;

    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic [XLEN-1:0] w_res;

    assign w_a_abs = (op_signed && src1[XLEN-1]) ? -src1 : src1;
    assign w_b_abs = (op_signed && src2[XLEN-1]) ? -src2 : src2;

    // One iteration: BITS_PER_CYCLE restoring shift-subtract steps, MSB first.
    // The trial difference is one bit wider than the remainder so its top
    // bit is the borrow, i.e. "shifted remainder < divisor".
    always_comb begin
        logic [XLEN:0] w_sh;
        logic [XLEN:0] w_trial;
        w_rem   = r_rem;
        w_quo   = r_quo;
        w_sh    = '0;
        w_trial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_sh    = {w_rem, w_quo[XLEN-1]};
            w_trial = w_sh - {1'b0, r_dvs};
            if (w_trial[XLEN]) begin
                w_rem = w_sh[XLEN-1:0];
            end else begin
                w_rem = w_trial[XLEN-1:0];
            end
            w_quo = {w_quo[XLEN-2:0], ~w_trial[XLEN]};
        end
    end

    // With a zero divisor the datapath already leaves |src1| in the
    // remainder, and sign restoration turns it back into src1, so only
    // the quotient needs an override.
    assign w_q_fin = r_divzero ? '1 : (r_qneg ? -w_quo : w_quo);
    assign w_r_fin = r_rneg ? -w_rem : w_rem;
    assign w_res   = r_sel_rem ? w_r_fin : w_q_fin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_sel_rem   <= 1'b0;
            r_divzero   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rem       <= '0;
                        r_quo       <= w_a_abs;
                        r_dvs       <= w_b_abs;
                        r_qneg      <= (src1[XLEN-1] ^ src2[XLEN-1]) & op_signed;
                        r_rneg      <= src1[XLEN-1] & op_signed;
                        r_sel_rem   <= op_rem;
                        r_divzero   <= (src2 == '0);
                        r_cnt       <= CW'(N);
                        r_state     <= S_CALC;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_result    <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ex_iter_divider.sv
// tb_ex_iter_divider: scoreboard bench for ex_iter_divider.
// Three instances (1, 2, 4 bits per cycle) run the same requests in lockstep.
module tb_ex_iter_divider;

    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] r;
        int              k;
    } exp_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic            in_valid;
    logic            op_signed;
    logic            op_rem;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_ready;
    logic [2:0]      in_ready;
    logic [2:0]      out_valid;
    logic [2:0]      busy;
    logic [XLEN-1:0] result [3];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int g);
        return (g == 0) ? XLEN : ((g == 1) ? XLEN / 2 : XLEN / 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int B = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        ex_iter_divider #(
            .XLEN          (XLEN),
            .BITS_PER_CYCLE(B)
        ) u_dut (
            .clk      (clk),
            .resetn   (resetn),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .op_signed(op_signed),
            .op_rem   (op_rem),
            .src1     (src1),
            .src2     (src2),
            .flush    (flush),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .result   (result[g]),
            .busy     (busy[g])
        );
    end

    task automatic chk(input string nm, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every rising out_valid.
    logic            prev_ov [3] = '{1'b0, 1'b0, 1'b0};
    logic [XLEN-1:0] held    [3];

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (out_valid[g] && !prev_ov[g]) begin
                if (sbq[g].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result dut%0d: got %h want none",
                             g, result[g]);
                end else begin
                    e = sbq[g].pop_front();
                    chk($sformatf("result_dut%0d", g), result[g], e.r);
                    chk($sformatf("latency_dut%0d", g),
                        XLEN'(cyc - e.k), XLEN'(lat_of(g)));
                end
                held[g] = result[g];
            end else if (out_valid[g]) begin
                chk($sformatf("hold_result_dut%0d", g), result[g], held[g]);
            end
            prev_ov[g] = out_valid[g];
        end
    end

    function automatic logic [XLEN-1:0] ref_div(input logic sg, input logic rm,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] mn;
        mn = {1'b1, {(XLEN-1){1'b0}}};
        if (b == '0) return rm ? a : '1;
        if (sg) begin
            if (a == mn && b == '1) return rm ? '0 : mn;
            return rm ? XLEN'($signed(a) % $signed(b))
                      : XLEN'($signed(a) / $signed(b));
        end
        return rm ? a % b : a / b;
    endfunction

    task automatic send(input logic sg, input logic rm,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] expv, input bit push);
        int t;
        exp_t e;
        t = 0;
        while (in_ready !== 3'b111 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready %b want 111", in_ready);
        end
        op_signed = sg;
        op_rem    = rm;
        src1      = a;
        src2      = b;
        in_valid  = 1'b1;
        if (push) begin
            e.r = expv;
            e.k = cyc + 1;
            for (int g = 0; g < 3; g++) sbq[g].push_back(e);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        src1      = ~a;
        src2      = ~b;
        op_rem    = ~rm;
        op_signed = ~sg;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL result_timeout: got %0d pending want 0",
                     sbq[0].size() + sbq[1].size() + sbq[2].size());
            for (int g = 0; g < 3; g++) sbq[g].delete();
        end
    endtask

    task automatic do_op(input logic sg, input logic rm,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] expv);
        send(sg, rm, a, b, expv, 1'b1);
        drain();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            sg;
        logic            rm;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        op_signed = 1'b0;
        op_rem    = 1'b0;
        src1      = '0;
        src2      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", XLEN'(out_valid), '0);
        chk("rst_busy", XLEN'(busy), '0);
        for (int g = 0; g < 3; g++) chk("rst_result", result[g], '0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", XLEN'(in_ready), XLEN'(3'b111));

        // Directed vectors, hand-computed.
        do_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
        do_op(1'b0, 1'b1, 32'd100, 32'd7, 32'd2);
        do_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        do_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1);
        do_op(1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        do_op(1'b1, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678);
        do_op(1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        do_op(1'b0, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678);
        do_op(1'b1, 1'b1, 32'h8765_4321, 32'd0, 32'h8765_4321);
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
        do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10, 32'hF);
        do_op(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        do_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);

        // Back-pressure: result held while out_ready is low.
        out_ready = 1'b0;
        send(1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 1'b1);
        repeat (40) @(negedge clk);
        chk("hold_in_ready", XLEN'(in_ready), '0);
        chk("hold_out_valid", XLEN'(out_valid), XLEN'(3'b111));
        repeat (20) @(negedge clk);
        chk("hold_busy", XLEN'(busy), XLEN'(3'b111));
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", XLEN'(in_ready), XLEN'(3'b111));
        chk("release_out_valid", XLEN'(out_valid), '0);
        chk("release_busy", XLEN'(busy), '0);

        // Flush mid-calculation: nothing delivered.
        send(1'b0, 1'b0, 32'd77, 32'd3, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_flush_busy", XLEN'(busy), XLEN'(3'b111));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", XLEN'(busy), '0);
        chk("flush_in_ready", XLEN'(in_ready), XLEN'(3'b111));
        chk("flush_out_valid", XLEN'(out_valid), '0);
        repeat (40) @(negedge clk);
        do_op(1'b0, 1'b0, 32'd50, 32'd5, 32'd10);

        // Flush and in_valid together: request dropped.
        src1     = 32'd50;
        src2     = 32'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_req_busy", XLEN'(busy), '0);
        chk("flush_req_in_ready", XLEN'(in_ready), XLEN'(3'b111));
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-calculation.
        send(1'b1, 1'b0, 32'd99, 32'd9, 32'd11, 1'b0);
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", XLEN'(busy), '0);
        chk("arst_out_valid", XLEN'(out_valid), '0);
        for (int g = 0; g < 3; g++) chk("arst_result", result[g], '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", XLEN'(in_ready), XLEN'(3'b111));
        do_op(1'b1, 1'b0, 32'd99, 32'd9, 32'd11);

        // Mixed pairs against the reference model.
        for (int i = 0; i < 60; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 20)) : $urandom;
            sg = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            do_op(sg, rm, a, b, ref_div(sg, rm, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
